// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS checker: FSM encoding, error counter width
// and default feedback taps for common LFSR lengths.
package prbs_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int ERR_W = 16;

    // Maximal-length tap masks for the "shift left, feed XOR of tapped bits" form
    function automatic logic [31:0] default_taps(input int w);
        case (w)
            2:       return 32'b11;
            3:       return 32'b110;
            4:       return 32'b1100;
            5:       return 32'b10100;
            6:       return 32'b110000;
            7:       return 32'b1100000;
            8:       return 32'b10111000;
            default: return 32'b11 << (w - 2);
        endcase
    endfunction

endpackage

// File: rtl/prbs_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over the old value
// but a coincident increment still counts, so clr+inc yields 1.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Clear-then-increment, holding at all-ones instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= inc ? W'(1) : '0;
        else if (inc && (count != '1))
            count <= count + W'(1);
    end

endmodule

// File: rtl/prbs_checker.sv
// PRBS checker: fills a local LFSR from the received stream, verifies a run of
// predicted bits, then free-runs its own LFSR and counts bit errors while locked.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int               WIDTH      = 3,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(default_taps(WIDTH)),
    parameter int               LOCK_COUNT = 8,
    parameter int               LOSS_COUNT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam int              FW        = $clog2(WIDTH + 1);
    localparam logic [FW-1:0]   FILL_LAST = FW'(WIDTH - 1);
    localparam logic [7:0]      LOCK_LAST = 8'(LOCK_COUNT - 1);
    localparam logic [7:0]      LOSS_LAST = 8'(LOSS_COUNT - 1);

    state_t         state;
    logic [WIDTH-1:0] s;
    logic [FW-1:0]  fill_cnt;
    logic [7:0]     match_cnt;
    logic [7:0]     miss_cnt;

    logic             p;
    logic [WIDTH-1:0] s_rx;
    logic             count_err;

    assign p         = ^(s & TAPS);
    assign s_rx      = {s[WIDTH-2:0], bit_in};
    // Only mismatches seen while locked are errors; VERIFY mismatches are search
    assign count_err = bit_valid && (state == LOCKED) && (bit_in != p);

    // Sync FSM: fill, verify prediction run, then free-run and track losses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= FILL;
            s         <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (bit_valid) begin
                case (state)
                    FILL: begin
                        s <= s_rx;
                        if (fill_cnt == FILL_LAST) begin
                            fill_cnt <= '0;
                            // All-zero state is the LFSR lock-up point; refill
                            if (s_rx != '0) begin
                                state     <= VERIFY;
                                match_cnt <= '0;
                            end
                        end else begin
                            fill_cnt <= fill_cnt + FW'(1);
                        end
                    end
                    VERIFY: begin
                        s <= s_rx;
                        if (bit_in == p) begin
                            if (match_cnt == LOCK_LAST) begin
                                state     <= LOCKED;
                                locked    <= 1'b1;
                                match_cnt <= '0;
                                miss_cnt  <= '0;
                            end else begin
                                match_cnt <= match_cnt + 8'd1;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        // Free-run on the prediction so line errors don't corrupt S
                        s <= {s[WIDTH-2:0], p};
                        if (bit_in != p) begin
                            err_pulse <= 1'b1;
                            if (miss_cnt == LOSS_LAST) begin
                                state     <= FILL;
                                locked    <= 1'b0;
                                s         <= '0;
                                fill_cnt  <= '0;
                                match_cnt <= '0;
                                miss_cnt  <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + 8'd1;
                            end
                        end else begin
                            miss_cnt <= '0;
                        end
                    end
                    default: state <= FILL;
                endcase
            end
        end
    end

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .rst   (reset),
        .clr   (err_clr),
        .inc   (count_err),
        .count (err_count)
    );

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker (WIDTH=3, TAPS=110, sequence 0010111).
module tb_prbs_checker;
    import prbs_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        err_clr = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;

    int checks = 0;
    int errors = 0;
    int idx = 0;
    logic [6:0] mseq = 7'b0010111;   // mseq[6] is the first bit sent

    prbs_checker dut (
        .clk       (clk),
        .reset     (reset),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .err_clr   (err_clr),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, then sample 1ns after the capturing edge
    task automatic step(input logic b, input logic v, input logic c);
        @(negedge clk);
        bit_in = b; bit_valid = v; err_clr = c;
        @(posedge clk);
        #1;
        bit_valid = 1'b0; err_clr = 1'b0;
    endtask

    function automatic logic seq_bit(input int i);
        return mseq[6 - (i % 7)];
    endfunction

    task automatic good();
        step(seq_bit(idx), 1'b1, 1'b0);
        idx++;
    endtask

    task automatic bad(input logic c);
        step(~seq_bit(idx), 1'b1, c);
        idx++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idx = 0;
    endtask

    initial begin
        // Reset state
        do_reset();
        #1;
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_pulse", {31'd0, err_pulse}, 32'd0);
        chk("rst_count", {16'd0, err_count}, 32'd0);
        chk("rst_state", {30'd0, dut.state}, {30'd0, FILL});

        // Lock after 3 fill + 8 matches
        repeat (10) good();
        chk("lock_not_yet", {31'd0, locked}, 32'd0);
        good();
        chk("lock_11", {31'd0, locked}, 32'd1);
        chk("lock_count0", {16'd0, err_count}, 32'd0);

        // Single flipped bit
        bad(1'b0);
        chk("flip1_pulse", {31'd0, err_pulse}, 32'd1);
        chk("flip1_count", {16'd0, err_count}, 32'd1);
        chk("flip1_locked", {31'd0, locked}, 32'd1);
        good();
        chk("flip1_next_pulse", {31'd0, err_pulse}, 32'd0);
        chk("flip1_next_count", {16'd0, err_count}, 32'd1);
        repeat (5) good();
        chk("flip1_tail_count", {16'd0, err_count}, 32'd1);
        chk("flip1_tail_locked", {31'd0, locked}, 32'd1);

        // err_clr alone, on an idle cycle
        step(1'b1, 1'b0, 1'b1);
        chk("clr_alone", {16'd0, err_count}, 32'd0);
        chk("idle_pulse", {31'd0, err_pulse}, 32'd0);

        // Three consecutive flips drop lock
        bad(1'b0);
        chk("loss1_pulse", {31'd0, err_pulse}, 32'd1);
        chk("loss1_locked", {31'd0, locked}, 32'd1);
        bad(1'b0);
        chk("loss2_pulse", {31'd0, err_pulse}, 32'd1);
        bad(1'b0);
        chk("loss3_pulse", {31'd0, err_pulse}, 32'd1);
        chk("loss3_count", {16'd0, err_count}, 32'd3);
        chk("loss3_locked", {31'd0, locked}, 32'd0);
        chk("loss3_state", {30'd0, dut.state}, {30'd0, FILL});
        repeat (10) good();
        chk("relock_not_yet", {31'd0, locked}, 32'd0);
        chk("relock_count", {16'd0, err_count}, 32'd3);
        good();
        chk("relock_11", {31'd0, locked}, 32'd1);

        // err_clr with coincident counted error
        bad(1'b1);
        chk("clr_inc_count", {16'd0, err_count}, 32'd1);
        chk("clr_inc_locked", {31'd0, locked}, 32'd1);
        good();

        // Saturation: preload near the top
        @(negedge clk);
        force dut.u_err_cnt.count = 16'hFFFE;
        #1;
        release dut.u_err_cnt.count;
        bad(1'b0);
        chk("sat_reach", {16'd0, err_count}, 32'h0000FFFF);
        good();
        bad(1'b0);
        chk("sat_hold", {16'd0, err_count}, 32'h0000FFFF);
        chk("sat_pulse", {31'd0, err_pulse}, 32'd1);
        good();
        chk("sat_locked", {31'd0, locked}, 32'd1);

        // Asynchronous reset mid-lock takes effect before any edge
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_locked", {31'd0, locked}, 32'd0);
        chk("async_rst_count", {16'd0, err_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        idx = 0;

        // Constant-zero stream never leaves FILL
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 1'b1, 1'b0);
            chk("zero_state", {30'd0, dut.state}, {30'd0, FILL});
        end
        chk("zero_locked", {31'd0, locked}, 32'd0);
        chk("zero_count", {16'd0, err_count}, 32'd0);

        // Gapped bit_valid: invalid cycles carry garbage and must be ignored
        do_reset();
        for (int i = 0; i < 11; i++) begin
            good();
            step(~seq_bit(idx), 1'b0, 1'b0);
            chk("gap_pulse", {31'd0, err_pulse}, 32'd0);
            if (i == 9) chk("gap_not_yet", {31'd0, locked}, 32'd0);
        end
        chk("gap_locked", {31'd0, locked}, 32'd1);
        chk("gap_count", {16'd0, err_count}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("gap_rst_locked", {31'd0, locked}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
